lsu_wb_master: RTL and testbench

Load/store unit bus master for the rv32i core. It accepts one load or store request at a time from the execute stage. It converts the request into a single Wishbone classic cycle toward the data memory slave, with word-aligned address, byte selects and replicated write lanes. For loads, it extracts and sign- or zero-extends the addressed byte, halfword or word, then returns a one-cycle response to the core.

---
 rtl/lsu_wb_master.sv | 157 +++++++++++++++
 tb/tb_lsu_wb_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_master.sv
// Load/store unit Wishbone classic master: one request at a time, store lane
// replication with byte selects, and sign/zero extension of load data.
module lsu_wb_master #(
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [1:0]    L_LAST = 2'(RD_LAT);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUS    = 2'd1;
   localparam logic [1:0] RDWAIT = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic          we_q, uns_q, err_q;
   logic [31:0]   addr_q, wdata_q, rdata_q;
   logic [1:0]    size_q;
   logic [TW-1:0] tcnt_q;
   logic [1:0]    lcnt_q;

   logic        bad_req, in_bus;
   logic [31:0] shifted, ext, dat;
   logic [3:0]  sel;

   assign bad_req = (req_size_i == 2'b11) ||
                    (req_size_i == 2'b01 && req_addr_i[0]) ||
                    (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
   assign in_bus  = (state_q == BUS);

   // Load extractor: align the addressed lane to bit 0, then extend.
   assign shifted = wb_dat_i >> {addr_q[1:0], 3'b000};
   always_comb begin
      case (size_q)
         2'b00:   ext = {{24{shifted[7] & ~uns_q}}, shifted[7:0]};
         2'b01:   ext = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   always_comb begin
      sel = 4'b0000;
      dat = 32'h0;
      case (size_q)
         2'b00: begin
            sel = 4'b0001 << addr_q[1:0];
            dat = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            sel = addr_q[1] ? 4'b1100 : 4'b0011;
            dat = {2{wdata_q[15:0]}};
         end
         2'b10: begin
            sel = 4'b1111;
            dat = wdata_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (req_valid_i) state_d = bad_req ? RESP : BUS;
         BUS: begin
            // A late ack in the final timeout cycle still completes the access.
            if (wb_ack_i)                state_d = (we_q || RD_LAT == 0) ? RESP : RDWAIT;
            else if (tcnt_q == T_LAST)   state_d = RESP;
         end
         RDWAIT: if (lcnt_q == L_LAST) state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         size_q  <= 2'b00;
         tcnt_q  <= '0;
         lcnt_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  we_q    <= req_we_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  size_q  <= req_size_i;
                  uns_q   <= req_unsigned_i;
                  err_q   <= bad_req;
                  tcnt_q  <= '0;
                  if (bad_req) rdata_q <= 32'h0;
               end
            end
            BUS: begin
               tcnt_q <= tcnt_q + TW'(1);
               lcnt_q <= 2'd1;
               if (wb_ack_i) begin
                  if (we_q)             rdata_q <= 32'h0;
                  else if (RD_LAT == 0) rdata_q <= ext;
               end else if (tcnt_q == T_LAST) begin
                  err_q   <= 1'b1;
                  rdata_q <= 32'h0;
               end
            end
            RDWAIT: begin
               lcnt_q <= lcnt_q + 2'd1;
               if (lcnt_q == L_LAST) rdata_q <= ext;
            end
            default: ;
         endcase
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_err_o   = (state_q == RESP) & err_q;
   assign rsp_rdata_o = rdata_q;

   assign wb_cyc_o = in_bus;
   assign wb_stb_o = in_bus;
   assign wb_we_o  = in_bus & we_q;
   assign wb_adr_o = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
   assign wb_sel_o = in_bus ? sel : 4'b0000;
   assign wb_dat_o = (in_bus & we_q) ? dat : 32'h0;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Bench for lsu_wb_master: byte-addressed memory model, directed cases and
// randomized loads/stores against a Wishbone slave with configurable waits.
module tb_lsu_wb_master;

   localparam int unsigned TOUT = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [1:0]  req_size_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;

   always #5 clk = ~clk;

   lsu_wb_master #(.RD_LAT(1), .TIMEOUT(TOUT)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o),
      .wb_cyc_o       (wb_cyc_o),
      .wb_stb_o       (wb_stb_o),
      .wb_we_o        (wb_we_o),
      .wb_adr_o       (wb_adr_o),
      .wb_sel_o       (wb_sel_o),
      .wb_dat_o       (wb_dat_o),
      .wb_dat_i       (wb_dat_i),
      .wb_ack_i       (wb_ack_i)
   );

   // Slave: registered read data (one cycle after ack), optional wait states.
   logic [31:0] smem [16];
   logic [31:0] rmem [16];
   int          wait_states = 0;
   bit          no_ack = 1'b0;
   bit          load_mem = 1'b0;
   int          wcnt = 0;

   assign wb_ack_i = wb_cyc_o && wb_stb_o && !no_ack && (wcnt == wait_states);

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 16; i++) smem[i] <= rmem[i];
      end
      if (wb_cyc_o && wb_stb_o && !wb_ack_i) wcnt <= wcnt + 1;
      else                                   wcnt <= 0;
      if (wb_ack_i) begin
         wb_dat_i <= smem[wb_adr_o[5:2]];
         if (wb_we_o) begin
            for (int i = 0; i < 4; i++)
               if (wb_sel_o[i]) smem[wb_adr_o[5:2]][8*i +: 8] <= wb_dat_o[8*i +: 8];
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: memory viewed as little-endian bytes.
   function automatic logic [31:0] mem_byte(input logic [31:0] a);
      return (rmem[a[5:2]] >> (8 * a[1:0])) & 32'hFF;
   endfunction

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit is_bad(input logic [31:0] a, input logic [1:0] s);
      return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
   endfunction

   function automatic logic [31:0] read_model(input logic [31:0] a, input logic [1:0] s,
                                              input bit uns);
      logic [31:0] v;
      int nb;
      v  = 32'h0;
      nb = nbytes(s);
      for (int k = 0; k < nb; k++) v = v | (mem_byte(a + k) << (8 * k));
      if (!uns && nb < 4 && v >= (1 << (8 * nb - 1))) v = v - (1 << (8 * nb));
      return v;
   endfunction

   task automatic write_model(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s);
      logic [31:0] b, w, ba;
      int sh;
      for (int k = 0; k < nbytes(s); k++) begin
         ba = a + k;
         b  = (wd >> (8 * k)) & 32'hFF;
         sh = 8 * ba[1:0];
         w  = rmem[ba[5:2]];
         rmem[ba[5:2]] = (w & ~(32'hFF << sh)) | (b << sh);
      end
   endtask

   // Results of the last transaction.
   int          r_lat, r_cyc;
   bit          r_got, r_stb_bad;
   logic [31:0] r_rdata, r_adr, r_dat;
   logic [3:0]  r_sel;
   logic        r_err, r_we, r_after_valid, r_after_ready;

   // Called at a negedge with the DUT idle; returns at a negedge in IDLE.
   task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] s, input bit uns);
      r_lat = 0; r_cyc = 0; r_got = 0; r_stb_bad = 0;
      r_rdata = 'x; r_err = 'x; r_adr = 'x; r_dat = 'x; r_sel = 'x; r_we = 'x;
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = wd;
      req_size_i = s; req_unsigned_i = uns;
      @(negedge clk);
      req_valid_i = 1'b0; req_we_i = 1'($urandom); req_addr_i = $urandom;
      req_wdata_i = $urandom; req_size_i = 2'($urandom); req_unsigned_i = 1'($urandom);
      for (int n = 1; n <= 40; n++) begin
         if (wb_stb_o !== wb_cyc_o) r_stb_bad = 1;
         if (wb_cyc_o === 1'b1) begin
            if (r_cyc == 0) begin
               r_sel = wb_sel_o; r_dat = wb_dat_o; r_adr = wb_adr_o; r_we = wb_we_o;
            end
            r_cyc++;
         end
         if (rsp_valid_o === 1'b1) begin
            r_got = 1; r_lat = n; r_rdata = rsp_rdata_o; r_err = rsp_err_o;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      r_after_valid = rsp_valid_o;
      r_after_ready = req_ready_o;
   endtask

   task automatic run_op(input string tag, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] s, input bit uns);
      bit bad;
      int nb;
      logic [31:0] exp_rd, exp_dat;
      bad    = is_bad(a, s);
      nb     = nbytes(s);
      exp_rd = (bad || we) ? 32'h0 : read_model(a, s, uns);
      exp_dat = !we ? 32'h0 : (nb == 1) ? (wd & 32'hFF) * 32'h01010101 :
                (nb == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      check({tag, " ready"}, req_ready_o, 1);
      do_req(we, a, wd, s, uns);
      check({tag, " got"}, r_got, 1);
      check({tag, " lat"}, r_lat, bad ? 1 : (we ? 2 : 3) + wait_states);
      check({tag, " err"}, r_err, bad);
      check({tag, " rdata"}, r_rdata, exp_rd);
      check({tag, " cyc"}, r_cyc, bad ? 0 : 1 + wait_states);
      check({tag, " stb"}, r_stb_bad, 0);
      check({tag, " pulse"}, r_after_valid, 0);
      check({tag, " idle"}, r_after_ready, 1);
      if (!bad) begin
         check({tag, " sel"}, r_sel, ((1 << nb) - 1) << (a % 4));
         check({tag, " dat"}, r_dat, exp_dat);
         check({tag, " adr"}, r_adr, a & ~32'h3);
         check({tag, " we"}, r_we, we);
         if (we) write_model(a, wd, s);
      end
   endtask

   logic [31:0] w2, ra, rw;
   logic [1:0]  rs;
   bit          seen;

   initial begin
      reset_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 32'h0;
      req_wdata_i = 32'h0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
      for (int i = 0; i < 16; i++) rmem[i] = $urandom;
      rmem[0] = 32'h12345678;
      rmem[1] = 32'hDEADBEEF;
      load_mem = 1'b1;
      repeat (3) @(negedge clk);
      load_mem = 1'b0;

      check("rst ready", req_ready_o, 1);
      check("rst rsp_valid", rsp_valid_o, 0);
      check("rst rsp_err", rsp_err_o, 0);
      check("rst rsp_rdata", rsp_rdata_o, 0);
      check("rst cyc", wb_cyc_o, 0);
      check("rst stb", wb_stb_o, 0);
      check("rst we", wb_we_o, 0);
      check("rst adr", wb_adr_o, 0);
      check("rst sel", wb_sel_o, 0);
      check("rst dat", wb_dat_o, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("post-rst ready", req_ready_o, 1);

      run_op("lw0", 0, 32'h0, 32'h0, 2'd2, 0);
      check("lw0 const", r_rdata, 32'h12345678);
      run_op("lb7", 0, 32'h7, 32'h0, 2'd0, 0);
      check("lb7 const", r_rdata, 32'hFFFFFFDE);
      run_op("lbu4", 0, 32'h4, 32'h0, 2'd0, 1);
      check("lbu4 const", r_rdata, 32'h000000EF);
      run_op("lh6", 0, 32'h6, 32'h0, 2'd1, 0);
      check("lh6 const", r_rdata, 32'hFFFFDEAD);
      run_op("lhu4", 0, 32'h4, 32'h0, 2'd1, 1);
      check("lhu4 const", r_rdata, 32'h0000BEEF);

      w2 = rmem[2];
      run_op("sb9", 1, 32'h9, 32'hCDEF12AB, 2'd0, 0);
      check("sb9 sel const", r_sel, 4'b0010);
      check("sb9 dat const", r_dat, 32'hABABABAB);
      run_op("lw8", 0, 32'h8, 32'h0, 2'd2, 0);
      check("lw8 const", r_rdata, (w2 & 32'hFFFF00FF) | 32'h0000AB00);
      run_op("sha", 1, 32'hA, 32'h55551234, 2'd1, 0);
      check("sha sel const", r_sel, 4'b1100);
      check("sha dat const", r_dat, 32'h12341234);

      run_op("lw2 bad", 0, 32'h2, 32'h0, 2'd2, 0);
      run_op("sh1 bad", 1, 32'h1, 32'h77, 2'd1, 0);
      run_op("sz3 bad", 1, 32'h0, 32'hFFFF, 2'd3, 0);
      check("sz3 err const", r_err, 1);

      no_ack = 1'b1;
      do_req(0, 32'h4, 32'h0, 2'd2, 0);
      check("tout got", r_got, 1);
      check("tout cyc", r_cyc, TOUT);
      check("tout lat", r_lat, TOUT + 1);
      check("tout err", r_err, 1);
      check("tout rdata", r_rdata, 0);
      no_ack = 1'b0;
      wait_states = TOUT - 1;
      run_op("ack last", 0, 32'h4, 32'h0, 2'd2, 0);
      check("ack last const", r_rdata, 32'hDEADBEEF);

      // Reset while the bus cycle is stalled by a 3-wait slave.
      wait_states = 3;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h4; req_size_i = 2'd2;
      @(negedge clk);
      req_valid_i = 1'b0;
      check("mid cyc", wb_cyc_o, 1);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid rst cyc", wb_cyc_o, 0);
      check("mid rst stb", wb_stb_o, 0);
      check("mid rst valid", rsp_valid_o, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("mid ready", req_ready_o, 1);
      seen = 0;
      repeat (5) begin
         if (rsp_valid_o !== 1'b0) seen = 1;
         @(negedge clk);
      end
      check("mid no rsp", seen, 0);
      wait_states = 0;
      run_op("post mid", 0, 32'h4, 32'h0, 2'd2, 0);

      for (int i = 0; i < 40; i++) begin
         wait_states = $urandom_range(0, 2);
         rs = 2'($urandom);
         ra = $urandom_range(0, 63);
         if ($urandom_range(0, 3) != 0 && rs != 2'd3) ra = ra & ~((1 << rs) - 1);
         rw = $urandom;
         run_op("rnd", 1'($urandom), ra, rw, rs, 1'($urandom));
      end

      @(negedge clk);
      for (int i = 0; i < 16; i++) check("mem", smem[i], rmem[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
